genius_seq_engine: RTL and testbench
====================================

GENIUS_SEQ_ENGINE -- requirements
Module: genius_seq_engine

Interface
REQ-001 Parameter NBOT, default 4, number of buttons/LEDs; SHALL be 2, 4 or 8.
REQ-002 Parameter DEPTH, default 16, maximum sequence length; SHALL be 2..64.
REQ-003 Parameter SHOW_CYC, default 1000, clocks each LED is lit during playback.
REQ-004 Parameter GAP_CYC, default 500, dark clocks between playback symbols.
REQ-005 Parameter TIMEOUT_CYC, default 5000, idle clocks allowed per player press.
REQ-006 Parameter SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-007 clock  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 iniciar  in  1  level start request, sampled each clock.
REQ-010 botoes  in  NBOT  player buttons, active-high, synchronous to clock.
REQ-011 leds  out  NBOT  one-hot during playback, mirrors botoes during player input, else 0.
REQ-012 nivel  out  clog2(DEPTH+1)  current round length.
REQ-013 pronto, ganhou, perdeu, timeout  out  1 each  outcome flags.
REQ-014 db_estado  out  4  state encoding for debug.

Function
REQ-015 States: INICIAL, GERA, MOSTRA, PAUSA, ESPERA, CONFERE, PROXIMA, FIM_GANHOU, FIM_PERDEU.
REQ-016 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock in every state, reset to SEED.
REQ-017 INICIAL -> GERA when iniciar=1; nivel set to 0, pronto/ganhou/perdeu/timeout cleared on that transition.
REQ-018 GERA: write LFSR[log2(NBOT)-1:0] into sequence RAM at address nivel, increment nivel, go MOSTRA at index 0; exactly one clock.
REQ-019 MOSTRA: leds = one-hot of RAM[index] for exactly SHOW_CYC clocks, then PAUSA.
REQ-020 PAUSA: leds = 0 for GAP_CYC clocks; index+1 < nivel -> MOSTRA with index+1, else ESPERA with index 0.
REQ-021 Press = rising edge of OR(botoes); only presses detected in ESPERA are accepted; presses in other states discarded.
REQ-022 Accepted press captures botoes in a register and moves to CONFERE the next clock.
REQ-023 CONFERE: captured value equal to one-hot(RAM[index]) -> PROXIMA; any other value (multi-button, wrong button) -> FIM_PERDEU.
REQ-024 PROXIMA: index+1 < nivel -> ESPERA, index+1; index+1 = nivel and nivel = DEPTH -> FIM_GANHOU; else -> GERA.
REQ-025 Timeout counter clears on entry to ESPERA; reaching TIMEOUT_CYC in ESPERA -> FIM_PERDEU with timeout=1.
REQ-026 FIM_GANHOU asserts pronto=1, ganhou=1; FIM_PERDEU asserts pronto=1, perdeu=1; flags hold until next accepted iniciar.
REQ-027 iniciar in FIM_* -> GERA (new game, nivel restarts from 0); iniciar in any other non-INICIAL state ignored.
REQ-028 Press-to-outcome latency: edge detected clock t, CONFERE at t+1, flags/next state visible at t+2.
REQ-029 Press and timeout on the same clock: press wins.

Reset
REQ-030 reset=0 at any clock, mid-game included, SHALL force INICIAL, nivel=0, index=0, all counters 0, leds=0, all flags 0, edge register 0, LFSR=SEED.
REQ-031 RAM contents need no reset; GERA always writes before any read of that address.

Structure
REQ-032 Package genius_pkg holds state encoding constants, LFSR taps and default SEED.
REQ-033 One sub-module genius_lfsr (16-bit, synchronous active-low reset, seed parameter); edge detection, RAM and counters inline.
REQ-034 SHOW/GAP/timeout share one cycle counter sized clog2(max(SHOW_CYC,GAP_CYC,TIMEOUT_CYC)+1).

Verification (NBOT=4, DEPTH=4, SHOW_CYC=4, GAP_CYC=2, TIMEOUT_CYC=20)
REQ-035 iniciar pulse, echo every shown symbol correctly for 4 rounds -> 10 playback flashes of 4 clocks each, ganhou=1, pronto=1, nivel=4.
REQ-036 Round 2, wrong button on second press -> perdeu=1 exactly 2 clocks after press edge, timeout=0, nivel=2.
REQ-037 Round 1, no press for 20 clocks in ESPERA -> perdeu=1, timeout=1; 19 idle clocks then correct press -> game continues.
REQ-038 Buttons 0 and 1 pressed together in ESPERA -> perdeu=1; any press held during MOSTRA -> no effect, playback timing unchanged.
REQ-039 reset=0 for one clock during MOSTRA of round 3 -> next clock INICIAL, leds=0, nivel=0, LFSR=SEED; subsequent iniciar replays identical sequence.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared constants for the Genius memory game: FSM state encoding,
// LFSR feedback taps and the default LFSR seed.
package genius_pkg;

    localparam logic [3:0] INICIAL    = 4'd0;
    localparam logic [3:0] GERA       = 4'd1;
    localparam logic [3:0] MOSTRA     = 4'd2;
    localparam logic [3:0] PAUSA      = 4'd3;
    localparam logic [3:0] ESPERA     = 4'd4;
    localparam logic [3:0] CONFERE    = 4'd5;
    localparam logic [3:0] PROXIMA    = 4'd6;
    localparam logic [3:0] FIM_GANHOU = 4'd7;
    localparam logic [3:0] FIM_PERDEU = 4'd8;

    // Taps 16,14,13,11 counted from 1 at the LSB end, i.e. bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/genius_seq_engine_if.sv
// Player-facing bundle of the game engine: start/buttons in, LEDs,
// round length, outcome flags and debug state out.
interface genius_seq_engine_if #(
    parameter int NBOT  = 4,
    parameter int DEPTH = 16
);
    localparam int NW = $clog2(DEPTH + 1);

    logic            iniciar;
    logic [NBOT-1:0] botoes;
    logic [NBOT-1:0] leds;
    logic [NW-1:0]   nivel;
    logic            pronto;
    logic            ganhou;
    logic            perdeu;
    logic            timeout;
    logic [3:0]      db_estado;

    modport master (
        output iniciar, botoes,
        input  leds, nivel, pronto, ganhou, perdeu, timeout, db_estado
    );

    modport slave (
        input  iniciar, botoes,
        output leds, nivel, pronto, ganhou, perdeu, timeout, db_estado
    );

endinterface

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes only the low OUT_W bits
// the game needs as its random symbol source.
module genius_lfsr
    import genius_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          OUT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic [OUT_W-1:0] value
);

    logic [15:0] state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

    assign value = state[OUT_W-1:0];

endmodule

// File: rtl/genius_seq_engine.sv
// Genius (Simon) game engine: grows a random sequence one symbol per round,
// plays it back on the LEDs and checks the player's button echoes.
module genius_seq_engine
    import genius_pkg::*;
#(
    parameter int          NBOT        = 4,
    parameter int          DEPTH       = 16,
    parameter int          SHOW_CYC    = 1000,
    parameter int          GAP_CYC     = 500,
    parameter int          TIMEOUT_CYC = 5000,
    parameter logic [15:0] SEED        = DEFAULT_SEED
) (
    input logic                clock,
    input logic                reset,
    genius_seq_engine_if.slave bus
);

    localparam int BW = $clog2(NBOT);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(max3(SHOW_CYC, GAP_CYC, TIMEOUT_CYC) + 1);

    localparam logic [CW-1:0] SHOW_LAST    = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [NW-1:0] DEPTH_N      = NW'(DEPTH);

    logic [3:0]      state;
    logic [NW-1:0]   nivel;
    logic [NW-1:0]   index;
    logic [NW-1:0]   index_next;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   ram [DEPTH];
    logic [BW-1:0]   sym_new;
    logic [NBOT-1:0] shown;
    logic [NBOT-1:0] captured;
    logic [NBOT-1:0] leds;
    logic            prev_any;
    logic            press;
    logic            pronto;
    logic            ganhou;
    logic            perdeu;
    logic            timeout;

    genius_lfsr #(
        .SEED  (SEED),
        .OUT_W (BW)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (sym_new)
    );

    assign press      = (|bus.botoes) && !prev_any;
    assign index_next = index + 1'b1;
    assign shown      = NBOT'(1) << ram[index[AW-1:0]];

    // Sequence memory is never reset: GERA always fills an address before it is read.
    always_ff @(posedge clock) begin
        if (state == GERA) begin
            ram[nivel[AW-1:0]] <= sym_new;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= INICIAL;
            nivel    <= '0;
            index    <= '0;
            cnt      <= '0;
            captured <= '0;
            prev_any <= 1'b0;
            pronto   <= 1'b0;
            ganhou   <= 1'b0;
            perdeu   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            prev_any <= |bus.botoes;
            case (state)
                INICIAL, FIM_GANHOU, FIM_PERDEU: begin
                    if (bus.iniciar) begin
                        state   <= GERA;
                        nivel   <= '0;
                        index   <= '0;
                        pronto  <= 1'b0;
                        ganhou  <= 1'b0;
                        perdeu  <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                GERA: begin
                    nivel <= nivel + 1'b1;
                    index <= '0;
                    cnt   <= '0;
                    state <= MOSTRA;
                end
                MOSTRA: begin
                    if (cnt == SHOW_LAST) begin
                        cnt   <= '0;
                        state <= PAUSA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PAUSA: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (index_next < nivel) begin
                            index <= index_next;
                            state <= MOSTRA;
                        end else begin
                            index <= '0;
                            state <= ESPERA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A press on the final allowed clock still beats the timeout.
                ESPERA: begin
                    if (press) begin
                        captured <= bus.botoes;
                        state    <= CONFERE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state   <= FIM_PERDEU;
                        pronto  <= 1'b1;
                        perdeu  <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONFERE: begin
                    if (captured == shown) begin
                        state <= PROXIMA;
                    end else begin
                        state  <= FIM_PERDEU;
                        pronto <= 1'b1;
                        perdeu <= 1'b1;
                    end
                end
                PROXIMA: begin
                    if (index_next < nivel) begin
                        index <= index_next;
                        cnt   <= '0;
                        state <= ESPERA;
                    end else if (nivel == DEPTH_N) begin
                        state  <= FIM_GANHOU;
                        pronto <= 1'b1;
                        ganhou <= 1'b1;
                    end else begin
                        state <= GERA;
                    end
                end
                default: state <= INICIAL;
            endcase
        end
    end

    always_comb begin
        leds = '0;
        if (state == MOSTRA) begin
            leds = shown;
        end else if (state == ESPERA) begin
            leds = bus.botoes;
        end
    end

    assign bus.leds      = leds;
    assign bus.nivel     = nivel;
    assign bus.pronto    = pronto;
    assign bus.ganhou    = ganhou;
    assign bus.perdeu    = perdeu;
    assign bus.timeout   = timeout;
    assign bus.db_estado = state;

endmodule

// File: tb/tb_genius_seq_engine.sv
// Self-checking bench for genius_seq_engine: round-1 outcome table, full
// randomized winning game, wrong press in round 2 and mid-game reset replay.
module tb_genius_seq_engine;
    import genius_pkg::*;

    localparam int          NBOT        = 4;
    localparam int          DEPTH       = 4;
    localparam int          SHOW_CYC    = 4;
    localparam int          GAP_CYC     = 2;
    localparam int          TIMEOUT_CYC = 20;
    localparam logic [15:0] SEED        = 16'hACE1;

    localparam int M_CORRECT = 0;
    localparam int M_WRONG   = 1;
    localparam int M_FIXED   = 2;
    localparam int M_TIMEOUT = 3;

    typedef struct {
        int         mode;
        logic [3:0] btn;
        int         idle;
        logic       exp_perdeu;
        logic       exp_timeout;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mdl_lfsr;
    int          checks = 0;
    int          errors = 0;
    int          flashes = 0;
    int          seq[$];
    int          saved[$];
    bit          use_saved = 1'b0;
    vec_t        vecs[6];

    genius_seq_engine_if #(.NBOT(NBOT), .DEPTH(DEPTH)) bus ();

    genius_seq_engine #(
        .NBOT        (NBOT),
        .DEPTH       (DEPTH),
        .SHOW_CYC    (SHOW_CYC),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SEED        (SEED)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference random source: shift left, new LSB = XOR of taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int x;
        int fb;
        x  = int'(v);
        fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return 16'(((x << 1) | fb) & 16'hFFFF);
    endfunction

    always @(posedge clock) begin
        mdl_lfsr <= !reset ? SEED : lfsr_step(mdl_lfsr);
    end

    function automatic logic [3:0] onehot(input int s);
        return 4'(1 << s);
    endfunction

    function automatic int next_symbol();
        if (use_saved && seq.size() < saved.size()) begin
            return saved[seq.size()];
        end
        return int'(mdl_lfsr[1:0]);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic ini, input logic [3:0] btn);
        bus.iniciar = ini;
        bus.botoes  = btn;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_flags(input string name, input logic [3:0] exp_prgpt);
        check_output(name, 32'({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout}), 32'(exp_prgpt));
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 4'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic start_game();
        apply_stimulus(1'b1, 4'b0);
        step();
        check_output("start_state", 32'(bus.db_estado), 32'(GERA));
        check_output("start_nivel", 32'(bus.nivel), 32'd0);
        check_flags("start_flags", 4'b0000);
        seq.delete();
        seq.push_back(next_symbol());
        apply_stimulus(1'b0, 4'b0);
        step();
    endtask

    // noise: 0 quiet, 1 random buttons/iniciar during MOSTRA, 2 hold one button during MOSTRA
    task automatic play_back(input int noise);
        logic [3:0] last_led;
        last_led = 4'b0;
        for (int i = 0; i < seq.size(); i++) begin
            for (int k = 0; k < SHOW_CYC; k++) begin
                if (noise == 1) begin
                    apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                end else if (noise == 2) begin
                    apply_stimulus(1'b0, 4'b0100);
                end
                #1;
                check_output("show_led", 32'(bus.leds), 32'(onehot(seq[i])));
                if (bus.leds != 4'b0 && last_led == 4'b0) flashes++;
                last_led = bus.leds;
                step();
            end
            apply_stimulus(1'b0, 4'b0);
            for (int k = 0; k < GAP_CYC; k++) begin
                #1;
                check_output("gap_led", 32'(bus.leds), 32'd0);
                last_led = bus.leds;
                step();
            end
        end
        check_output("wait_state", 32'(bus.db_estado), 32'(ESPERA));
        check_output("wait_nivel", 32'(bus.nivel), 32'(seq.size()));
    endtask

    task automatic press(input logic [3:0] btn, input int idle);
        repeat (idle) step();
        apply_stimulus(1'b0, btn);
        #1;
        check_output("mirror_led", 32'(bus.leds), 32'(btn));
        step();
        check_output("press_accept", 32'(bus.db_estado), 32'(CONFERE));
        check_output("latency_t1", 32'(bus.perdeu), 32'd0);
        apply_stimulus(1'b0, 4'b0);
        step();
    endtask

    task automatic correct_press(input int i, input int idle);
        press(onehot(seq[i]), idle);
        check_output("confere_ok", 32'(bus.db_estado), 32'(PROXIMA));
        step();
        if (i + 1 < seq.size()) begin
            check_output("next_wait", 32'(bus.db_estado), 32'(ESPERA));
        end else if (seq.size() == DEPTH) begin
            check_output("win_state", 32'(bus.db_estado), 32'(FIM_GANHOU));
            check_flags("win_flags", 4'b1100);
            check_output("win_nivel", 32'(bus.nivel), 32'(DEPTH));
        end else begin
            check_output("next_gera", 32'(bus.db_estado), 32'(GERA));
            seq.push_back(next_symbol());
            step();
        end
    endtask

    task automatic play_round(input int noise, input int max_idle);
        int n;
        play_back(noise);
        n = seq.size();
        for (int i = 0; i < n; i++) begin
            correct_press(i, $urandom_range(0, max_idle));
        end
    endtask

    initial begin
        vecs[0] = '{M_CORRECT, 4'b0000, 0,  1'b0, 1'b0};
        vecs[1] = '{M_CORRECT, 4'b0000, 19, 1'b0, 1'b0};
        vecs[2] = '{M_WRONG,   4'b0000, 3,  1'b1, 1'b0};
        vecs[3] = '{M_FIXED,   4'b0011, 0,  1'b1, 1'b0};
        vecs[4] = '{M_FIXED,   4'b1111, 5,  1'b1, 1'b0};
        vecs[5] = '{M_TIMEOUT, 4'b0000, 0,  1'b1, 1'b1};

        apply_stimulus(1'b0, 4'b0);
        reset = 1'b0;
        step();
        step();
        check_output("rst_state", 32'(bus.db_estado), 32'(INICIAL));
        check_output("rst_leds", 32'(bus.leds), 32'd0);
        check_output("rst_nivel", 32'(bus.nivel), 32'd0);
        check_flags("rst_flags", 4'b0000);
        reset = 1'b1;
        step();
        check_output("idle_inicial", 32'(bus.db_estado), 32'(INICIAL));

        // Round-1 outcome table
        foreach (vecs[v]) begin
            do_reset();
            start_game();
            play_back(0);
            if (vecs[v].mode == M_TIMEOUT) begin
                repeat (TIMEOUT_CYC - 1) step();
                check_output("to_before", 32'(bus.perdeu), 32'd0);
                step();
            end else if (vecs[v].mode == M_CORRECT) begin
                press(onehot(seq[0]), vecs[v].idle);
            end else if (vecs[v].mode == M_WRONG) begin
                press(onehot((seq[0] + 1) % NBOT), vecs[v].idle);
            end else begin
                press(vecs[v].btn, vecs[v].idle);
            end
            check_output("vec_perdeu", 32'(bus.perdeu), 32'(vecs[v].exp_perdeu));
            check_output("vec_timeout", 32'(bus.timeout), 32'(vecs[v].exp_timeout));
            check_output("vec_pronto", 32'(bus.pronto), 32'(vecs[v].exp_perdeu));
            check_output("vec_ganhou", 32'(bus.ganhou), 32'd0);
            if (!vecs[v].exp_perdeu) begin
                check_output("vec_continue", 32'(bus.db_estado), 32'(PROXIMA));
            end
        end

        // Full winning game with random noise during playback and random reaction times
        do_reset();
        start_game();
        flashes = 0;
        for (int r = 0; r < DEPTH; r++) begin
            play_round(1, 6);
        end
        check_output("win_flashes", 32'(flashes), 32'd10);
        repeat (3) step();
        check_flags("win_hold", 4'b1100);
        check_output("win_hold_state", 32'(bus.db_estado), 32'(FIM_GANHOU));

        // New game from FIM_GANHOU; button held through playback changes nothing
        start_game();
        play_back(2);
        apply_stimulus(1'b0, 4'b0);
        correct_press(0, 0);

        // Wrong button on second press of round 2
        do_reset();
        start_game();
        play_round(0, 0);
        play_back(0);
        correct_press(0, 0);
        press(onehot((seq[1] + 1) % NBOT), 0);
        check_output("r2_perdeu", 32'(bus.perdeu), 32'd1);
        check_output("r2_timeout", 32'(bus.timeout), 32'd0);
        check_output("r2_nivel", 32'(bus.nivel), 32'd2);
        check_output("r2_state", 32'(bus.db_estado), 32'(FIM_PERDEU));
        start_game();

        // Reset during round-3 playback, then replay must show the same sequence
        do_reset();
        start_game();
        play_round(0, 0);
        play_round(0, 0);
        saved = seq;
        repeat (2) begin
            check_output("r3_show", 32'(bus.leds), 32'(onehot(seq[0])));
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_output("mid_rst_state", 32'(bus.db_estado), 32'(INICIAL));
        check_output("mid_rst_leds", 32'(bus.leds), 32'd0);
        check_output("mid_rst_nivel", 32'(bus.nivel), 32'd0);
        check_flags("mid_rst_flags", 4'b0000);
        use_saved = 1'b1;
        start_game();
        play_round(0, 0);
        play_round(0, 0);
        play_back(0);
        use_saved = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, time %0t limit 500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
